// File: rtl/clock_set_ctrl.sv
// Mode/time-setting controller for the digital clock counter chain: run-mode enables,
// set-mode load strobes. Optional inc auto-repeat when CLOCK_SET_AUTOREPEAT_EN is defined.
module clock_set_ctrl #(
    parameter int unsigned HOUR_MOD   = 24,
    parameter int unsigned REPEAT_DLY = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick,
    input  logic       i_btn_mode,
    input  logic       i_btn_inc,
    input  logic [6:0] i_sec_q,
    input  logic [6:0] i_min_q,
    input  logic [6:0] i_hr_q,
    output logic       o_sec_en,
    output logic       o_min_en,
    output logic       o_hr_en,
    output logic       o_sec_load,
    output logic       o_min_load,
    output logic       o_hr_load,
    output logic [6:0] o_sec_data,
    output logic [6:0] o_min_data,
    output logic [6:0] o_hr_data,
    output logic [1:0] o_mode
);

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StSetHr  = 2'b01,
        StSetMin = 2'b10
    } state_e;

    localparam logic [6:0] HrMax  = 7'(HOUR_MOD - 1);
    localparam logic [6:0] MinMax = 7'd59;

    state_e     r_state, w_state_d;
    logic       r_btn_mode, r_btn_inc;
    logic       w_mode_press, w_inc_press, w_rpt, w_inc_evt;
    logic       r_sec_load, r_min_load, r_hr_load;
    logic       w_sec_load_d, w_min_load_d, w_hr_load_d;
    logic [6:0] r_sec_data, r_min_data, r_hr_data;
    logic [6:0] w_sec_data_d, w_min_data_d, w_hr_data_d;

    assign w_mode_press = i_btn_mode & ~r_btn_mode;
    assign w_inc_press  = i_btn_inc & ~r_btn_inc;
    assign w_inc_evt    = w_inc_press | w_rpt;

`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam int unsigned HoldW = (REPEAT_DLY < 4) ? 2 : $clog2(REPEAT_DLY + 1);

    logic [HoldW-1:0] r_hold_cnt;
    logic             w_in_set;

    assign w_in_set = (r_state == StSetHr) || (r_state == StSetMin);
    assign w_rpt    = w_in_set & i_btn_inc & i_tick & (r_hold_cnt >= HoldW'(REPEAT_DLY));

    // Saturates at REPEAT_DLY; from then on every tick while held is a repeat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold_cnt <= '0;
        end else if (!w_in_set || !i_btn_inc || w_mode_press) begin
            r_hold_cnt <= '0;
        end else if (i_tick && (r_hold_cnt < HoldW'(REPEAT_DLY))) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end
`else
    assign w_rpt = 1'b0;
`endif

    always_comb begin
        w_state_d    = r_state;
        w_sec_load_d = 1'b0;
        w_min_load_d = 1'b0;
        w_hr_load_d  = 1'b0;
        w_sec_data_d = r_sec_data;
        w_min_data_d = r_min_data;
        w_hr_data_d  = r_hr_data;
        case (r_state)
            StRun: begin
                if (w_mode_press) w_state_d = StSetHr;
            end
            StSetHr: begin
                if (w_mode_press) begin
                    w_state_d = StSetMin;
                end else if (w_inc_evt) begin
                    w_hr_load_d = 1'b1;
                    w_hr_data_d = (i_hr_q >= HrMax) ? 7'd0 : i_hr_q + 7'd1;
                end
            end
            StSetMin: begin
                // Restart seconds on exit so timing resumes from a clean minute.
                if (w_mode_press) begin
                    w_state_d    = StRun;
                    w_sec_load_d = 1'b1;
                    w_sec_data_d = 7'd0;
                end else if (w_inc_evt) begin
                    w_min_load_d = 1'b1;
                    w_min_data_d = (i_min_q >= MinMax) ? 7'd0 : i_min_q + 7'd1;
                end
            end
            default: w_state_d = StRun;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StRun;
            r_btn_mode <= 1'b0;
            r_btn_inc  <= 1'b0;
            r_sec_load <= 1'b0;
            r_min_load <= 1'b0;
            r_hr_load  <= 1'b0;
            r_sec_data <= 7'd0;
            r_min_data <= 7'd0;
            r_hr_data  <= 7'd0;
        end else begin
            r_state    <= w_state_d;
            r_btn_mode <= i_btn_mode;
            r_btn_inc  <= i_btn_inc;
            r_sec_load <= w_sec_load_d;
            r_min_load <= w_min_load_d;
            r_hr_load  <= w_hr_load_d;
            r_sec_data <= w_sec_data_d;
            r_min_data <= w_min_data_d;
            r_hr_data  <= w_hr_data_d;
        end
    end

    assign o_sec_en   = (r_state == StRun) & i_tick;
    assign o_min_en   = o_sec_en & (i_sec_q == MinMax);
    assign o_hr_en    = o_min_en & (i_min_q == MinMax);
    assign o_sec_load = r_sec_load;
    assign o_min_load = r_min_load;
    assign o_hr_load  = r_hr_load;
    assign o_sec_data = r_sec_data;
    assign o_min_data = r_min_data;
    assign o_hr_data  = r_hr_data;
    assign o_mode     = r_state;

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Mode and time-setting controller for the digital clock datapath. Sits between the debounced front-panel buttons and the seconds/minutes/hours counter chain. In run mode it generates the per-counter count enables from the 1 Hz tick. In set modes it freezes counting and drives the counters' synchronous load/data ports to step hours and minutes.

## Interface
- HOUR_MOD, 24: hour counter modulus; hour value wraps HOUR_MOD-1 -> 0.
- REPEAT_DLY, 2: ticks of continuous inc hold before auto-repeat starts (used only with the configuration macro).
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  one-clk-wide 1 Hz pulse from the prescaler.
- btn_mode  in  1  debounced mode button, level, synchronous to clk.
- btn_inc  in  1  debounced increment button, level, synchronous to clk.
- sec_q, min_q, hr_q  in  7 each  current counter values.
- sec_en, min_en, hr_en  out  1 each  count enables.
- sec_load, min_load, hr_load  out  1 each  synchronous load strobes (priority over enable in the counters).
- sec_data, min_data, hr_data  out  7 each  preset values.
- mode  out  2  00 RUN, 01 SET_HR, 10 SET_MIN.

## Operation
- Button edges: btn_mode and btn_inc are registered once each. press = btn & ~btn_reg. One press per rising level; holding produces no further presses.
- FSM states and transitions:
  - RUN -> SET_HR on mode press.
  - SET_HR -> SET_MIN on mode press.
  - SET_MIN -> RUN on mode press.
  - Encoding 11 is illegal and returns to RUN on the next clk.
- Enables, combinational:
  - sec_en = RUN & tick.
  - min_en = sec_en & (sec_q==59).
  - hr_en = min_en & (min_q==59).
  - All enables are 0 outside RUN; tick is ignored in set modes.
- SET_HR inc press: hr_load=1, hr_data = (hr_q>=HOUR_MOD-1) ? 0 : hr_q+1.
- SET_MIN inc press: min_load=1, min_data = (min_q>=59) ? 0 : min_q+1.
- Leaving SET_MIN for RUN: sec_load=1, sec_data=0, so timing restarts from a clean minute.
- Simultaneous mode and inc press: mode wins and inc is dropped.
- Only one load strobe is asserted in any cycle.
- Arithmetic is 7-bit unsigned. Out-of-range inputs (>= modulus) wrap to 0.

## Timing
- Press is detected at the first clk edge where btn=1 and btn_reg=0.
- The state update and load/data registers take effect on that same edge. The strobe is high for exactly one clk that follows it.
- The counter samples the load on the next edge, so the updated q is visible 2 clks after the press edge.
- The minimum spacing between detected presses is 2 clks, so data is always computed from updated q.
- Enables have zero latency from tick. The counters see the enable on the tick's own edge.
- Reset values:
  - mode = RUN (00).
  - btn registers 0.
  - All *_load 0 and all *_data 0.
  - Enables follow tick (effectively 0).
- Reset mid-set drops any pending strobe and returns to RUN. Counter contents are whatever they held.

## Configuration
- CLOCK_SET_AUTOREPEAT_EN defined:
  - In SET_HR/SET_MIN, a 2-bit-or-wider hold counter counts ticks while btn_inc stays high.
  - Once REPEAT_DLY ticks have elapsed, each further tick issues one increment, using the same load/data rules as a press.
  - The hold counter clears on btn_inc low, on a state change, or on reset.
  - A tick coinciding with a press yields one increment only.
- CLOCK_SET_AUTOREPEAT_EN undefined:
  - No hold counter is built and REPEAT_DLY is ignored.
  - Holding inc yields exactly one increment.

## Test plan
- Run rollover: RUN, sec_q=59, min_q=59, hr_q=23, tick pulse -> sec_en=min_en=hr_en=1 in that cycle. With sec_q=58, only sec_en=1.
- Set hours: mode press, then inc press with hr_q=23 -> mode=01, one-cycle hr_load=1, hr_data=0. A second inc with hr_q=5 gives hr_data=6.
- Set minutes and exit: two mode presses, inc with min_q=59 -> min_data=0. Then a mode press -> sec_load=1, sec_data=0, mode=00.
- Freeze and priority: in SET_HR, tick pulses give all enables 0. Mode and inc rising in the same cycle -> state advances to SET_MIN with no hr_load.
- Reset: assert rst low mid-SET_MIN with an inc press pending -> mode=00 and all loads 0 immediately (async). Release -> normal RUN enables on the next tick.
- Auto-repeat (macro on, REPEAT_DLY=2): hold inc in SET_MIN for 5 ticks with min_q starting at 10 -> loads with data 11 (press), then 12 on the 3rd tick, 13 on the 4th, 14 on the 5th. Macro off -> only 11.
